ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register of the 5-stage MIPS core. It sits directly downstream of the ALU and captures ALU out/zero together with the instruction's control bits, store data and destination register.
- It resolves conditional branches (BEQ/BNE) from the ALU zero flag and emits a one-cycle taken pulse with the target address.
- It drives the MEM stage and the forwarding unit.
- It supports stall (hold) and flush (bubble insertion) from the hazard unit.
- It keeps a saturating count of taken branches for debug.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold all stage registers this cycle.
- flush  in  1  replace stage contents with a bubble; wins over stall.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_alu_out  in  DATA_W  ALU result.
- ex_zero  in  1  ALU zero flag (result == 0).
- ex_store_data  in  DATA_W  rt value for SW.
- ex_rd  in  5  destination register index.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_branch  in  1  instruction is a conditional branch.
- ex_branch_ne  in  1  1 = BNE, 0 = BEQ.
- ex_branch_target  in  DATA_W  computed branch target.
- mem_valid  out  1  stage holds a real instruction.
- mem_alu_out  out  DATA_W  registered ALU result (memory address or writeback value).
- mem_store_data  out  DATA_W  registered store data.
- mem_rd  out  5  registered destination index.
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control bits.
- fwd_valid  out  1  forwarding candidate: mem_valid & mem_reg_write & (mem_rd != 0).
- branch_taken  out  1  one-cycle pulse, branch resolved taken.
- branch_target  out  DATA_W  registered target; meaningful only while branch_taken = 1.
- taken_count  out  CNT_W  number of taken branches, saturating.

Behaviour:
- Reset: while rst_n = 0, every output and internal register is 0 immediately, with no clock required. The first update occurs on the first rising clk edge after rst_n rises.
- Priority each edge is flush > stall > load.
- Load (flush = 0, stall = 0):
  - mem_valid <= ex_valid.
  - Data fields (alu_out, store_data, rd, branch_target) load unconditionally.
  - Control bits load as ex_* & ex_valid; an invalid input becomes a bubble with all controls 0.
- Stall (flush = 0, stall = 1):
  - mem_valid, data and control registers hold their values.
  - branch_taken <= 0; a held branch never re-pulses.
- Flush:
  - mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and branch_taken <= 0.
  - Data fields <= 0.
  - Applies regardless of stall.
- Branch resolution:
  - take = ex_valid & ex_branch & (ex_zero ^ ex_branch_ne).
  - On load: branch_taken <= take, and branch_target <= ex_branch_target.
  - branch_taken is high for exactly one cycle per taken branch.
- Latency: one clk from ex_* to mem_* and branch_taken.
- taken_count increments by 1 on each load edge where take = 1. It holds at all-ones (2^CNT_W−1) once reached. It is unaffected by stall/flush edges and cleared only by reset.
- fwd_valid is combinational from the stage registers only, with no path from ex_* inputs.
- ex_mem_read and ex_mem_write both 1 is illegal upstream. The stage does not check it and passes both bits through.

Test Plan:
- Reset mid-stream: load {alu_out=0x1234, reg_write=1, rd=5}, assert rst_n=0 between edges -> all outputs 0 immediately, before the next edge; fwd_valid = 0.
- BEQ taken: ex_valid=1, ex_branch=1, ex_branch_ne=0, ex_zero=1, target=0x00400020 -> next cycle branch_taken=1, branch_target=0x00400020; following cycle branch_taken=0; taken_count=1.
- BNE not taken, then invalid: ex_branch_ne=1, ex_zero=1 -> branch_taken=0. Then ex_branch=1, ex_valid=0 -> branch_taken=0, mem_valid=0, all mem controls 0.
- Stall hold: load LW {alu_out=0x10010004, rd=8}, then stall for 3 cycles with different ex_* values -> outputs unchanged for 3 cycles. Then stall=0 loads the new values.
- Flush vs stall: stage holds SW, apply flush=1 and stall=1 together -> mem_valid=0, mem_mem_write=0, mem_alu_out=0. A taken branch on that edge produces no pulse and taken_count is unchanged.
- Counter saturation: CNT_W=2, issue 5 taken branches -> taken_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results and control bits, resolves
// BEQ/BNE from the ALU zero flag, and keeps a saturating taken-branch counter.

package ex_mem_stage_pkg;

    localparam int unsigned RD_W = 5;

    // Memory/writeback control bits carried alongside each instruction
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

endpackage

module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [RD_W-1:0]   ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic              ex_branch_ne,
    input  logic [DATA_W-1:0] ex_branch_target,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [RD_W-1:0]   mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              fwd_valid,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              valid_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] store_q;
    logic [RD_W-1:0]   rd_q;
    mem_ctrl_t         ctrl_q;
    mem_ctrl_t         ctrl_in_c;
    logic              taken_q;
    logic [DATA_W-1:0] target_q;
    logic [CNT_W-1:0]  count_q;
    logic              take_c;
    logic              load_c;

    // Branch decision and incoming control bits masked by validity
    always_comb begin
        take_c              = ex_valid & ex_branch & (ex_zero ^ ex_branch_ne);
        load_c              = ~flush & ~stall;
        ctrl_in_c.reg_write = ex_reg_write & ex_valid;
        ctrl_in_c.mem_read  = ex_mem_read  & ex_valid;
        ctrl_in_c.mem_write = ex_mem_write & ex_valid;
    end

    // Stage registers: flush bubbles, stall holds, otherwise load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (flush) begin
            valid_q  <= 1'b0;
            alu_q    <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (stall) begin
            // A held branch must not pulse a second time
            taken_q  <= 1'b0;
        end else begin
            valid_q  <= ex_valid;
            alu_q    <= ex_alu_out;
            store_q  <= ex_store_data;
            rd_q     <= ex_rd;
            ctrl_q   <= ctrl_in_c;
            taken_q  <= take_c;
            target_q <= ex_branch_target;
        end
    end

    // Saturating count of branches taken on load edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_c && take_c && (count_q != CNT_MAX)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Output mapping; forwarding qualifier depends on stage registers only
    always_comb begin
        mem_valid      = valid_q;
        mem_alu_out    = alu_q;
        mem_store_data = store_q;
        mem_rd         = rd_q;
        mem_reg_write  = ctrl_q.reg_write;
        mem_mem_read   = ctrl_q.mem_read;
        mem_mem_write  = ctrl_q.mem_write;
        fwd_valid      = valid_q & ctrl_q.reg_write & (rd_q != '0);
        branch_taken   = taken_q;
        branch_target  = target_q;
        taken_count    = count_q;
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, branch resolution, stall, flush,
// and counter saturation (second instance with a 2-bit counter).

module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_out;
    logic        ex_zero;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_branch_ne;
    logic [31:0] ex_branch_target;

    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        fwd_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [15:0] taken_count;

    logic        s_mem_valid;
    logic [31:0] s_mem_alu_out;
    logic [31:0] s_mem_store_data;
    logic [4:0]  s_mem_rd;
    logic        s_mem_reg_write;
    logic        s_mem_mem_read;
    logic        s_mem_mem_write;
    logic        s_fwd_valid;
    logic        s_branch_taken;
    logic [31:0] s_branch_target;
    logic [1:0]  s_taken_count;

    int total = 0;
    int bad   = 0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_branch_target(ex_branch_target),
        .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .fwd_valid(fwd_valid),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .taken_count(taken_count)
    );

    ex_mem_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_zero(ex_zero),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_branch_ne(ex_branch_ne), .ex_branch_target(ex_branch_target),
        .mem_valid(s_mem_valid), .mem_alu_out(s_mem_alu_out),
        .mem_store_data(s_mem_store_data), .mem_rd(s_mem_rd),
        .mem_reg_write(s_mem_reg_write), .mem_mem_read(s_mem_mem_read),
        .mem_mem_write(s_mem_mem_write), .fwd_valid(s_fwd_valid),
        .branch_taken(s_branch_taken), .branch_target(s_branch_target),
        .taken_count(s_taken_count)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [31:0] alu, input logic z,
                          input logic [31:0] sd, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw,
                          input logic br, input logic bne, input logic [31:0] tgt);
        ex_valid = v; ex_alu_out = alu; ex_zero = z; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_branch = br; ex_branch_ne = bne; ex_branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_valid", 32'(mem_valid), 0);
        chk("rst_count", 32'(taken_count), 0);
        #11 rst_n = 1'b1;

        // Reset mid-stream
        set_ex(1, 32'h1234, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        tick();
        chk("ld_alu", mem_alu_out, 32'h1234);
        chk("ld_rd", 32'(mem_rd), 5);
        chk("ld_fwd", 32'(fwd_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_alu", mem_alu_out, 0);
        chk("mrst_rd", 32'(mem_rd), 0);
        chk("mrst_rw", 32'(mem_reg_write), 0);
        chk("mrst_valid", 32'(mem_valid), 0);
        chk("mrst_fwd", 32'(fwd_valid), 0);
        #2 rst_n = 1'b1;

        // BEQ taken
        set_ex(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0020);
        tick();
        chk("beq_taken", 32'(branch_taken), 1);
        chk("beq_target", branch_target, 32'h0040_0020);
        chk("beq_count", 32'(taken_count), 1);
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("beq_pulse_end", 32'(branch_taken), 0);
        chk("beq_count_hold", 32'(taken_count), 1);

        // BNE not taken, then invalid branch
        set_ex(1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h100);
        tick();
        chk("bne_nt", 32'(branch_taken), 0);
        chk("bne_valid", 32'(mem_valid), 1);
        set_ex(0, 32'h55, 1, 0, 3, 1, 1, 0, 1, 0, 32'h104);
        tick();
        chk("inv_taken", 32'(branch_taken), 0);
        chk("inv_valid", 32'(mem_valid), 0);
        chk("inv_rw", 32'(mem_reg_write), 0);
        chk("inv_mr", 32'(mem_mem_read), 0);
        chk("inv_mw", 32'(mem_mem_write), 0);
        chk("inv_fwd", 32'(fwd_valid), 0);
        chk("inv_alu", mem_alu_out, 32'h55);
        chk("inv_count", 32'(taken_count), 1);

        // Stall hold with a taken branch waiting upstream
        set_ex(1, 32'h1001_0004, 0, 0, 8, 1, 1, 0, 0, 0, 0);
        tick();
        chk("lw_alu", mem_alu_out, 32'h1001_0004);
        chk("lw_mr", 32'(mem_mem_read), 1);
        stall = 1'b1;
        set_ex(1, 32'hdead_beef, 1, 32'h1111, 9, 0, 0, 1, 1, 0, 32'h200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stl_alu", mem_alu_out, 32'h1001_0004);
            chk("stl_rd", 32'(mem_rd), 8);
            chk("stl_mr", 32'(mem_mem_read), 1);
            chk("stl_mw", 32'(mem_mem_write), 0);
            chk("stl_taken", 32'(branch_taken), 0);
            chk("stl_count", 32'(taken_count), 1);
        end
        stall = 1'b0;
        tick();
        chk("unstl_alu", mem_alu_out, 32'hdead_beef);
        chk("unstl_rd", 32'(mem_rd), 9);
        chk("unstl_sd", mem_store_data, 32'h1111);
        chk("unstl_mw", 32'(mem_mem_write), 1);
        chk("unstl_mr", 32'(mem_mem_read), 0);
        chk("unstl_taken", 32'(branch_taken), 1);
        chk("unstl_target", branch_target, 32'h200);
        chk("unstl_count", 32'(taken_count), 2);
        chk("unstl_fwd", 32'(fwd_valid), 0);

        // Flush wins over stall; taken branch on that edge is dropped
        set_ex(1, 32'habc, 0, 32'h77, 0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("sw_mw", 32'(mem_mem_write), 1);
        flush = 1'b1; stall = 1'b1;
        set_ex(1, 32'h999, 1, 32'h88, 4, 1, 0, 0, 1, 0, 32'h300);
        tick();
        chk("fl_valid", 32'(mem_valid), 0);
        chk("fl_mw", 32'(mem_mem_write), 0);
        chk("fl_alu", mem_alu_out, 0);
        chk("fl_sd", mem_store_data, 0);
        chk("fl_taken", 32'(branch_taken), 0);
        chk("fl_count", 32'(taken_count), 2);
        flush = 1'b0; stall = 1'b0;

        // Counter saturation on the 2-bit instance
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        set_ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h400);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_taken", 32'(s_branch_taken), 1);
            chk("sat_count2", 32'(s_taken_count), (i < 3) ? 32'(i + 1) : 32'd3);
            chk("sat_count16", 32'(taken_count), 32'(i + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
